cmpscan: RTL and testbench

Parametrised bitmap margin analyser for the compare accelerator. Accepts a COLS-column by ROWS-row bitmap one column per handshake, and measures the empty margins on all four sides: left, right, top and bottom. It then derives 2x horizontal and vertical scale flags from programmable thresholds. It sits between the bitmap column fetcher and the normalisation/shift unit, and supersedes the fixed 64x24 left/bottom-only comparator.

---
 rtl/cmpscan.sv | 200 ++++++++++++++++++++
 tb/tb_cmpscan.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmpscan.sv
// cmpscan: bitmap margin analyser.
// Takes a COLS x ROWS bitmap one column per handshake. It measures the empty
// left/right/top/bottom margins and derives the 2x horizontal and vertical
// scale flags.
// Optional build macro CMPSCAN_LENCHK_EN enables frame length checking: the
// frame also ends on the COLSth column, and err flags an early col_last.
//
// Handshake: a column beat is transferred on a rising edge where
// col_valid & col_ready are both high. col_ready depends only on the FSM state
// (high in SCAN). The sender holds col_data/col_last stable while col_valid is
// high and not yet accepted. A start pulse in the same cycle wins, and that
// beat is dropped.
module cmpscan #(
  parameter int COLS           = 24,
  parameter int ROWS           = 64,
  parameter int SCALE_H_THRESH = 12,
  parameter int SCALE_V_THRESH = 32,
  localparam int CW = $clog2(COLS + 1),
  localparam int RW = $clog2(ROWS + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            col_valid,
  input  logic [ROWS-1:0] col_data,
  input  logic            col_last,
  output logic            col_ready,
  output logic            done,
  output logic [CW-1:0]   lshift,
  output logic [CW-1:0]   rshift,
  output logic [RW-1:0]   tshift,
  output logic [RW-1:0]   bshift,
  output logic            scale_h,
  output logic            scale_v,
  output logic            blank,
  output logic            err,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_REDUCE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [CW-1:0] COLS_MAX = CW'(COLS);

  state_t          state, state_next;
  logic [ROWS-1:0] row_mask;
  logic [CW-1:0]   col_cnt, lead_cnt, trail_cnt;
  logic [CW-1:0]   col_inc, lead_inc, trail_inc;
  logic            seen;
  logic            accept;
  logic            frame_end;
  logic [RW-1:0]   tz, lz;
  logic [CW:0]     h_sum;
  logic [RW:0]     v_sum;

  assign col_ready = (state == S_SCAN);
  assign accept    = col_valid & col_ready & ~start;
  assign state_dbg = state;

  // Counters stop at COLS so over-long frames cannot wrap.
  assign col_inc   = (col_cnt   == COLS_MAX) ? col_cnt   : col_cnt   + 1'b1;
  assign lead_inc  = (lead_cnt  == COLS_MAX) ? lead_cnt  : lead_cnt  + 1'b1;
  assign trail_inc = (trail_cnt == COLS_MAX) ? trail_cnt : trail_cnt + 1'b1;

`ifdef CMPSCAN_LENCHK_EN
  assign frame_end = col_last | (col_inc == COLS_MAX);
`else
  assign frame_end = col_last;
`endif

  // Margin sums are one bit wider than their operands, so they never overflow.
  assign h_sum = {1'b0, lead_cnt} + {1'b0, trail_cnt};
  assign v_sum = {1'b0, tz} + {1'b0, lz};

  // Trailing-zero count of the row mask (empty rows at the top, bit 0 = top).
  always_comb begin
    tz = RW'(ROWS);
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (row_mask[i]) tz = RW'(i);
    end
  end

  // Leading-zero count of the row mask (empty rows at the bottom).
  always_comb begin
    lz = RW'(ROWS);
    for (int i = 0; i < ROWS; i++) begin
      if (row_mask[i]) lz = RW'(ROWS - 1 - i);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; start always (re)enters SCAN from any state.
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = S_SCAN;
    end else begin
      case (state)
        S_IDLE:   state_next = S_IDLE;
        S_SCAN:   if (accept && frame_end) state_next = S_REDUCE;
        S_REDUCE: state_next = S_DONE;
        S_DONE:   state_next = S_DONE;
        default:  state_next = S_IDLE;
      endcase
    end
  end

`ifdef CMPSCAN_LENCHK_EN
  logic err_pend;
  // Remember whether the frame ended early on col_last, and publish it with done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pend <= 1'b0;
      err      <= 1'b0;
    end else if (start) begin
      err_pend <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (accept) err_pend <= col_last && (col_inc != COLS_MAX);
      if (state == S_REDUCE) err <= err_pend;
    end
  end
`else
  assign err = 1'b0;
`endif

  // Column accumulation during SCAN and result capture in REDUCE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_mask  <= '0;
      col_cnt   <= '0;
      lead_cnt  <= '0;
      trail_cnt <= '0;
      seen      <= 1'b0;
      done      <= 1'b0;
      lshift    <= '0;
      rshift    <= '0;
      tshift    <= '0;
      bshift    <= '0;
      scale_h   <= 1'b0;
      scale_v   <= 1'b0;
      blank     <= 1'b0;
    end else if (start) begin
      row_mask  <= '0;
      col_cnt   <= '0;
      lead_cnt  <= '0;
      trail_cnt <= '0;
      seen      <= 1'b0;
      done      <= 1'b0;
      lshift    <= '0;
      rshift    <= '0;
      tshift    <= '0;
      bshift    <= '0;
      scale_h   <= 1'b0;
      scale_v   <= 1'b0;
      blank     <= 1'b0;
    end else begin
      if (accept) begin
        row_mask <= row_mask | col_data;
        col_cnt  <= col_inc;
        if (col_data == '0) begin
          if (!seen) lead_cnt <= lead_inc;
          trail_cnt <= trail_inc;
        end else begin
          trail_cnt <= '0;
          seen      <= 1'b1;
        end
      end
      if (state == S_REDUCE) begin
        done  <= 1'b1;
        blank <= ~seen;
        if (!seen) begin
          lshift  <= col_cnt;
          rshift  <= '0;
          tshift  <= RW'(ROWS);
          bshift  <= '0;
          scale_h <= 1'b0;
          scale_v <= 1'b0;
        end else begin
          lshift  <= lead_cnt;
          rshift  <= trail_cnt;
          tshift  <= tz;
          bshift  <= lz;
          scale_h <= (int'(h_sum) >= SCALE_H_THRESH);
          scale_v <= (int'(v_sum) >= SCALE_V_THRESH);
        end
      end
    end
  end

endmodule

// File: tb/tb_cmpscan.sv
// tb_cmpscan: directed bench for cmpscan with default parameters.
// Builds with or without CMPSCAN_LENCHK_EN; the length tests adapt.
`timescale 1ns/1ps
module tb_cmpscan;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        col_valid;
  logic [63:0] col_data;
  logic        col_last;
  logic        col_ready;
  logic        done;
  logic [4:0]  lshift, rshift;
  logic [6:0]  tshift, bshift;
  logic        scale_h, scale_v, blank, err;
  logic [1:0]  state_dbg;

  // {blank, lshift, rshift, tshift, bshift, scale_h, scale_v, err}
  logic [27:0] res;
  assign res = {blank, lshift, rshift, tshift, bshift, scale_h, scale_v, err};

  int tests_run    = 0;
  int tests_failed = 0;

  logic [63:0] frame_cols [0:31];
  int          frame_len;

`ifdef CMPSCAN_LENCHK_EN
  localparam logic EXP_SHORT_ERR = 1'b1;
`else
  localparam logic EXP_SHORT_ERR = 1'b0;
`endif

  cmpscan #(
    .COLS(24), .ROWS(64), .SCALE_H_THRESH(12), .SCALE_V_THRESH(32)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .col_valid(col_valid),
    .col_data(col_data), .col_last(col_last), .col_ready(col_ready),
    .done(done), .lshift(lshift), .rshift(rshift), .tshift(tshift),
    .bshift(bshift), .scale_h(scale_h), .scale_v(scale_v), .blank(blank),
    .err(err), .state_dbg(state_dbg)
  );

  // Clock and time limit.
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Driver tasks.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic fill(input int nl, input int nm, input int nt, input logic [63:0] d);
    frame_len = nl + nm + nt;
    for (int i = 0; i < frame_len; i++)
      frame_cols[i] = (i >= nl && i < nl + nm) ? d : 64'd0;
  endtask

  task automatic send_frame(input bit gap, input bit with_last);
    for (int i = 0; i < frame_len; i++) begin
      col_valid = 1'b1;
      col_data  = frame_cols[i];
      col_last  = with_last && (i == frame_len - 1);
      step();
      col_valid = 1'b0;
      col_last  = 1'b0;
      if (gap) begin
        col_data = {$urandom, $urandom};
        col_last = 1'($urandom_range(0, 1));
        step();
        col_last = 1'b0;
      end
    end
    col_data = 64'd0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 64) begin
      step();
      cyc++;
    end
  endtask

  // Tests.
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; col_valid = 1'b0; col_last = 1'b0; col_data = 64'd0;
    step(); step();
    tests_run++;
    if (res !== 28'd0 || done !== 1'b0 || col_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: res=%h done=%b ready=%b, want 0/0/0", res, done, col_ready);
    end
    rst = 1'b0;
    step(); step();
    tests_run++;
    if (col_ready !== 1'b0 || state_dbg !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_idle: ready=%b state=%0d, want 0/0", col_ready, state_dbg);
    end
  endtask

  task automatic test_centered();
    do_start();
    tests_run++;
    if (col_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_ready: ready=%b want 1", col_ready);
    end
    fill(3, 18, 3, 64'h0000_00FF_FF00_0000);
    send_frame(1'b0, 1'b1);
    tests_run++;
    if (done !== 1'b0 || state_dbg !== 2'd2) begin
      tests_failed++;
      $display("FAIL latency_reduce: done=%b state=%0d want 0/2", done, state_dbg);
    end
    step();
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL latency_done: done=%b want 1", done);
    end
    tests_run++;
    if (res !== {1'b0, 5'd3, 5'd3, 7'd24, 7'd24, 1'b0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL centered_res: got %h want %h", res,
               {1'b0, 5'd3, 5'd3, 7'd24, 7'd24, 1'b0, 1'b1, 1'b0});
    end
    col_valid = 1'b1; col_data = '1; col_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      tests_run++;
      if (col_ready !== 1'b0 || done !== 1'b1 ||
          res !== {1'b0, 5'd3, 5'd3, 7'd24, 7'd24, 1'b0, 1'b1, 1'b0}) begin
        tests_failed++;
        $display("FAIL done_hold: ready=%b done=%b res=%h want 0/1/stable", col_ready, done, res);
      end
    end
    col_valid = 1'b0; col_last = 1'b0; col_data = 64'd0;
  endtask

  task automatic test_blank();
    int cyc;
    do_start();
    tests_run++;
    if (done !== 1'b0 || res !== 28'd0) begin
      tests_failed++;
      $display("FAIL start_clears: done=%b res=%h want 0/0", done, res);
    end
    fill(24, 0, 0, 64'd0);
    send_frame(1'b0, 1'b1);
    wait_done(cyc);
    tests_run++;
    if (done !== 1'b1 || res !== {1'b1, 5'd24, 5'd0, 7'd64, 7'd0, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL blank_res: done=%b got %h want %h", done, res,
               {1'b1, 5'd24, 5'd0, 7'd64, 7'd0, 1'b0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_corners();
    int cyc;
    fill(24, 0, 0, 64'd0);
    frame_cols[0]  = 64'h1;
    frame_cols[23] = 64'h8000_0000_0000_0000;
    for (int g = 0; g < 2; g++) begin
      do_start();
      send_frame(g[0], 1'b1);
      wait_done(cyc);
      tests_run++;
      if (done !== 1'b1 || res !== 28'd0) begin
        tests_failed++;
        $display("FAIL corners_gap%0d: done=%b got %h want done=1 res=0", g, done, res);
      end
    end
  endtask

  task automatic test_abort();
    int cyc;
    do_start();
    fill(0, 10, 0, 64'hFFFF);
    send_frame(1'b0, 1'b0);
    tests_run++;
    if (col_ready !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_mid: ready=%b done=%b want 1/0", col_ready, done);
    end
    start = 1'b1; col_valid = 1'b1; col_data = '1; col_last = 1'b0;
    step();
    start = 1'b0; col_valid = 1'b0; col_data = 64'd0;
    fill(8, 16, 0, 64'hF);
    send_frame(1'b0, 1'b1);
    wait_done(cyc);
    tests_run++;
    if (done !== 1'b1 || res !== {1'b0, 5'd8, 5'd0, 7'd0, 7'd60, 1'b0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL abort_res: done=%b got %h want %h", done, res,
               {1'b0, 5'd8, 5'd0, 7'd0, 7'd60, 1'b0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_thresholds();
    int cyc;
    do_start();
    fill(6, 12, 6, 64'h0000_0001_FFFF_FFFF);
    send_frame(1'b0, 1'b1);
    wait_done(cyc);
    tests_run++;
    if (done !== 1'b1 || res !== {1'b0, 5'd6, 5'd6, 7'd0, 7'd31, 1'b1, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL thresh_h12_v31: done=%b got %h want %h", done, res,
               {1'b0, 5'd6, 5'd6, 7'd0, 7'd31, 1'b1, 1'b0, 1'b0});
    end
    do_start();
    fill(5, 13, 6, 64'h0000_0000_FFFF_FFFF);
    send_frame(1'b0, 1'b1);
    wait_done(cyc);
    tests_run++;
    if (done !== 1'b1 || res !== {1'b0, 5'd5, 5'd6, 7'd0, 7'd32, 1'b0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL thresh_h11_v32: done=%b got %h want %h", done, res,
               {1'b0, 5'd5, 5'd6, 7'd0, 7'd32, 1'b0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_length();
    int cyc;
    do_start();
    fill(2, 16, 2, 64'hF0);
    send_frame(1'b0, 1'b1);
    wait_done(cyc);
    tests_run++;
    if (done !== 1'b1 || res !== {1'b0, 5'd2, 5'd2, 7'd4, 7'd56, 1'b0, 1'b1, EXP_SHORT_ERR}) begin
      tests_failed++;
      $display("FAIL short_frame: done=%b got %h want %h", done, res,
               {1'b0, 5'd2, 5'd2, 7'd4, 7'd56, 1'b0, 1'b1, EXP_SHORT_ERR});
    end
`ifdef CMPSCAN_LENCHK_EN
    do_start();
    fill(0, 24, 0, 64'h1);
    send_frame(1'b0, 1'b0);
    wait_done(cyc);
    tests_run++;
    if (done !== 1'b1 || res !== {1'b0, 5'd0, 5'd0, 7'd0, 7'd63, 1'b0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL lenchk_full: done=%b got %h want %h", done, res,
               {1'b0, 5'd0, 5'd0, 7'd0, 7'd63, 1'b0, 1'b1, 1'b0});
    end
    step();
    tests_run++;
    if (col_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL lenchk_ready: ready=%b want 0", col_ready);
    end
`else
    do_start();
    fill(24, 0, 0, 64'd0);
    send_frame(1'b0, 1'b0);
    tests_run++;
    if (col_ready !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL no_last_open: ready=%b done=%b want 1/0", col_ready, done);
    end
    fill(2, 0, 0, 64'd0);
    send_frame(1'b0, 1'b1);
    wait_done(cyc);
    tests_run++;
    if (done !== 1'b1 || res !== {1'b1, 5'd24, 5'd0, 7'd64, 7'd0, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL saturate: done=%b got %h want %h", done, res,
               {1'b1, 5'd24, 5'd0, 7'd64, 7'd0, 1'b0, 1'b0, 1'b0});
    end
`endif
  endtask

  task automatic test_rst_mid();
    int cyc;
    rst = 1'b1;
    #1;
    tests_run++;
    if (res !== 28'd0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_async_done: res=%h done=%b want 0/0", res, done);
    end
    rst = 1'b0;
    step();
    do_start();
    fill(0, 5, 0, 64'hFFFF_0000_0000_0000);
    send_frame(1'b0, 1'b0);
    rst = 1'b1;
    #1;
    tests_run++;
    if (col_ready !== 1'b0 || state_dbg !== 2'd0) begin
      tests_failed++;
      $display("FAIL rst_mid: ready=%b state=%0d want 0/0", col_ready, state_dbg);
    end
    rst = 1'b0;
    step(); step(); step();
    tests_run++;
    if (col_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_wait_start: ready=%b want 0", col_ready);
    end
    do_start();
    fill(3, 18, 3, 64'h0000_00FF_FF00_0000);
    send_frame(1'b0, 1'b1);
    wait_done(cyc);
    tests_run++;
    if (done !== 1'b1 || res !== {1'b0, 5'd3, 5'd3, 7'd24, 7'd24, 1'b0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL rst_then_frame: done=%b got %h want %h", done, res,
               {1'b0, 5'd3, 5'd3, 7'd24, 7'd24, 1'b0, 1'b1, 1'b0});
    end
  endtask

  // Test sequence and final report.
  initial begin
    test_reset();
    test_centered();
    test_blank();
    test_corners();
    test_abort();
    test_thresholds();
    test_length();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
